// File: rtl/hash_stream_ctrl.sv
// ---------------------------------------------------------------------------
// hash_stream_ctrl
//
// Purpose:
//   Streams a multi-chunk message through an external combinational 128-bit
//   Murmur hasher. The hasher takes one 128-bit chunk per clock. The hash of
//   each chunk becomes the seed for the next chunk. The controller counts the
//   chunks and presents one 32-bit digest per message on a valid/ready output.
//
// Optional feature (macro HASH_STREAM_FMIX_EN):
//   Defined   : adds a one-cycle MIX state. MIX applies the Murmur3 32-bit
//               finalization mix to the chained hash. The message length in
//               bytes is folded in first.
//   Undefined : the last chunk goes straight to DONE. The digest is the raw
//               chained hash.
//
// Parameters:
//   CNT_W     - width of the chunk counter and of out_len (4..28).
//
// Ports:
//   clk, rst_n          - clock (rising edge), synchronous active-low reset.
//   cfg_seed[31:0]      - initial seed, sampled on the first chunk only.
//   in_valid/in_ready   - chunk handshake.
//   in_chunk[127:0]     - chunk data.
//   in_last             - marks the final chunk of the message.
//   hs_seed, hs_chunk   - drive to the external hasher.
//   hs_hash             - combinational result from the external hasher.
//   out_valid/out_ready - digest handshake.
//   out_hash, out_len,
//   out_ovf             - digest, chunk count, count-saturated flag.
//   busy                - high whenever the controller is not IDLE.
// ---------------------------------------------------------------------------
module hash_stream_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      cfg_seed,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_chunk,
  input  logic             in_last,
  output logic [31:0]      hs_seed,
  output logic [127:0]     hs_chunk,
  input  logic [31:0]      hs_hash,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_hash,
  output logic [CNT_W-1:0] out_len,
  output logic             out_ovf,
  output logic             busy
);

`ifdef HASH_STREAM_FMIX_EN
  typedef enum logic [1:0] {S_IDLE, S_ABSORB, S_MIX, S_DONE} state_t;
  localparam state_t S_LAST = S_MIX;

  function automatic logic [31:0] fmix(input logic [31:0] h_in,
                                       input logic [31:0] len_bytes);
    logic [31:0] h;
    h = h_in ^ len_bytes;
    h = h ^ (h >> 16);
    h = h * 32'h85EB_CA6B;
    h = h ^ (h >> 13);
    h = h * 32'hC2B2_AE35;
    h = h ^ (h >> 16);
    return h;
  endfunction
`else
  typedef enum logic [1:0] {S_IDLE, S_ABSORB, S_DONE} state_t;
  localparam state_t S_LAST = S_DONE;
`endif

  state_t            state, state_nxt;
  logic [31:0]       acc, acc_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              ovf, ovf_nxt;
  logic              in_fire;

  // The hasher path is purely combinational. The seed comes from the config
  // port while IDLE, because that is the first chunk of a message. After
  // that, the seed is the running chain value.
  assign hs_chunk = in_chunk;
  assign hs_seed  = (state == S_IDLE) ? cfg_seed : acc;

  // The outputs are taken straight from the state registers. The registers
  // do not change in DONE, so the outputs hold stable under back-pressure.
  // Their reset value is zero.
  assign out_hash = acc;
  assign out_len  = cnt;
  assign out_ovf  = ovf;
  assign busy     = (state != S_IDLE);

  assign in_fire  = in_valid & in_ready;

  // NOTE: every signal written here gets a default first. Otherwise a path
  // that skips the assignment would infer a latch.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_fire) begin
          acc_nxt   = hs_hash;
          cnt_nxt   = CNT_W'(1);
          ovf_nxt   = 1'b0;
          state_nxt = in_last ? S_LAST : S_ABSORB;
        end
      end

      S_ABSORB: begin
        in_ready = 1'b1;
        if (in_fire) begin
          acc_nxt = hs_hash;
          // The counter saturates rather than wraps. An increment attempted
          // at all-ones flags the overflow for the rest of the message.
          if (&cnt) ovf_nxt = 1'b1;
          else      cnt_nxt = cnt + CNT_W'(1);
          if (in_last) state_nxt = S_LAST;
        end
      end

`ifdef HASH_STREAM_FMIX_EN
      S_MIX: begin
        acc_nxt   = fmix(acc, 32'({cnt, 4'b0000}));
        state_nxt = S_DONE;
      end
`endif

      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. The reset is
  // synchronous, so it is sampled inside the clocked block and overrides any
  // handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

endmodule
